// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus bridge: FSM states plus command and response byte codes.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    RESP  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [7:0] CMD_READ   = 8'h01;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] RSP_WR_OK  = 8'hAA;
  localparam logic [7:0] RSP_ERROR  = 8'hEE;

endpackage

// File: rtl/uart_bus_bridge.sv
// UART byte-stream to simple request/acknowledge bus bridge.
// A command byte is followed by big-endian address bytes, plus write-data bytes for a write.
// One bus access is then issued. The reply is the read data (MSB first), 0xAA after a write,
// or 0xEE when the command is bad or when a byte or bus timeout occurs.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_TIMEOUT = 5000000,
  parameter int BUS_TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_bus_req,
  output logic                  o_bus_rnw,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  output logic                  o_busy
);

  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES) + 1;
  localparam int BTO_W      = $clog2(BYTE_TIMEOUT + 1);
  localparam int BUS_W      = $clog2(BUS_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [BTO_W-1:0] BTO_LAST  = BTO_W'(BYTE_TIMEOUT - 1);
  localparam logic [BUS_W-1:0] BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [BTO_W-1:0]      byte_tmo_q, byte_tmo_d;
  logic [BUS_W-1:0]      bus_tmo_q, bus_tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rnw_q, rnw_d;
  logic                  req_q, req_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_accept;

  assign tx_accept = tx_valid_q & i_tx_ready;

  // Next-state, datapath shifting, timeout counting and response sequencing.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    byte_tmo_d = byte_tmo_q;
    bus_tmo_d  = bus_tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rnw_d      = rnw_q;
    req_d      = req_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          byte_cnt_d = '0;
          byte_tmo_d = '0;
          if (i_rx_data == CMD_READ) begin
            rnw_d   = 1'b1;
            state_d = ADDR;
          end else if (i_rx_data == CMD_WRITE) begin
            rnw_d   = 1'b0;
            state_d = ADDR;
          end else begin
            state_d    = ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ERROR;
          end
        end
      end
      ADDR: begin
        if (i_rx_valid) begin
          addr_d     = (addr_q << 8) | ADDR_WIDTH'(i_rx_data);
          byte_tmo_d = '0;
          if (byte_cnt_q == ADDR_LAST) begin
            byte_cnt_d = '0;
            if (rnw_q) begin
              state_d   = BUS;
              req_d     = 1'b1;
              bus_tmo_d = '0;
            end else begin
              state_d = WDATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (byte_tmo_q == BTO_LAST) begin
          state_d    = ERR;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ERROR;
        end else if (!(&byte_tmo_q)) begin
          byte_tmo_d = byte_tmo_q + 1'b1;
        end
      end
      WDATA: begin
        if (i_rx_valid) begin
          wdata_d    = (wdata_q << 8) | DATA_WIDTH'(i_rx_data);
          byte_tmo_d = '0;
          if (byte_cnt_q == DATA_LAST) begin
            byte_cnt_d = '0;
            state_d    = BUS;
            req_d      = 1'b1;
            bus_tmo_d  = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (byte_tmo_q == BTO_LAST) begin
          state_d    = ERR;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ERROR;
        end else if (!(&byte_tmo_q)) begin
          byte_tmo_d = byte_tmo_q + 1'b1;
        end
      end
      BUS: begin
        if (req_q && i_bus_ack) begin
          req_d      = 1'b0;
          state_d    = RESP;
          tx_valid_d = 1'b1;
          byte_cnt_d = '0;
          if (rnw_q) begin
            tx_data_d = i_bus_rdata[DATA_WIDTH-1 -: 8];
            rdata_d   = i_bus_rdata << 8;
          end else begin
            tx_data_d = RSP_WR_OK;
          end
        end else if (bus_tmo_q == BUS_LAST) begin
          req_d      = 1'b0;
          state_d    = ERR;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ERROR;
        end else if (!(&bus_tmo_q)) begin
          bus_tmo_d = bus_tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (tx_accept) begin
          if (rnw_q && (byte_cnt_q != DATA_LAST)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_data_d  = rdata_q[DATA_WIDTH-1 -: 8];
            rdata_d    = rdata_q << 8;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      ERR: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        req_d      = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      byte_tmo_q <= '0;
      bus_tmo_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rnw_q      <= 1'b0;
      req_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      byte_tmo_q <= byte_tmo_d;
      bus_tmo_q  <= bus_tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rnw_q      <= rnw_d;
      req_q      <= req_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_bus_req   = req_q;
  assign o_bus_rnw   = rnw_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed scenarios plus randomized traffic against a byte-level reference model.
module tb_uart_bus_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BTO = 40;
  localparam int BSO = 20;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk;
  logic          n_rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_bus_req;
  logic          o_bus_rnw;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_ack;
  logic [DW-1:0] i_bus_rdata;
  logic          o_busy;

  logic rdy_mode;
  logic rdy_manual;
  logic rnd_rdy;
  assign i_tx_ready = rdy_mode ? rnd_rdy : rdy_manual;

  int checks   = 0;
  int failures = 0;

  bq_t  tx_q;
  txn_t txn_q[$];
  int   run_q[$];
  int   tx_unstable  = 0;
  int   bus_unstable = 0;

  uart_bus_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_TIMEOUT(BTO), .BUS_TIMEOUT(BSO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_bus_req(o_bus_req), .o_bus_rnw(o_bus_rnw), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random ready generator, used only while rdy_mode is set.
  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, no summary yet");
    $fatal(1, "watchdog");
  end

  // Monitor on the falling edge: records accepted tx bytes, bus handshakes, req run lengths, and stability violations.
  logic       pv, pacc, pr, pack;
  logic [7:0] pd;
  txn_t       pbus;
  int         run;
  initial begin
    pv = 0; pacc = 0; pr = 0; pack = 0; pd = 0; pbus = '0; run = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pv = 0; pacc = 0; pr = 0; pack = 0; run = 0;
      end else begin
        if (pv && !pacc && (!o_tx_valid || o_tx_data !== pd)) tx_unstable++;
        if (pr && !pack && o_bus_req && ({o_bus_rnw, o_bus_addr, o_bus_wdata} !== pbus)) bus_unstable++;
        if (pr && pack && o_bus_req) bus_unstable++;
        if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
        if (o_bus_req && i_bus_ack) txn_q.push_back({o_bus_rnw, o_bus_addr, o_bus_wdata});
        if (o_bus_req) run++;
        else if (pr) begin
          run_q.push_back(run);
          run = 0;
        end
        pv   = o_tx_valid;
        pd   = o_tx_data;
        pacc = o_tx_valid && i_tx_ready;
        pr   = o_bus_req;
        pack = i_bus_ack;
        pbus = {o_bus_rnw, o_bus_addr, o_bus_wdata};
      end
    end
  end

  // Reference model: what a complete byte sequence must produce on the bus and on tx.
  function automatic void ref_model(input bq_t b, input bit acked, input logic [DW-1:0] rd,
                                    output bq_t exp_tx, output bit exp_bus, output txn_t exp_txn);
    int need;
    exp_tx  = {};
    exp_bus = 0;
    exp_txn = '0;
    if (b.size() > 0 && (b[0] == 8'h01 || b[0] == 8'h02)) begin
      need = 1 + AW / 8 + ((b[0] == 8'h02) ? DW / 8 : 0);
      if (b.size() == need) begin
        exp_bus     = 1;
        exp_txn.rnw = (b[0] == 8'h01);
        for (int i = 1; i <= AW / 8; i++) exp_txn.addr = (exp_txn.addr << 8) | AW'(b[i]);
        if (!exp_txn.rnw)
          for (int i = 1 + AW / 8; i < need; i++) exp_txn.wdata = (exp_txn.wdata << 8) | DW'(b[i]);
        if (!acked) exp_tx.push_back(8'hEE);
        else if (exp_txn.rnw) for (int i = DW / 8 - 1; i >= 0; i--) exp_tx.push_back(rd[i*8 +: 8]);
        else exp_tx.push_back(8'hAA);
      end
    end else begin
      exp_tx.push_back(8'hEE);
    end
  endfunction

  task automatic send_byte(input logic [7:0] v);
    @(posedge clk); #1;
    i_rx_data  = v;
    i_rx_valid = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    txn_q.delete();
    run_q.delete();
  endtask

  // Plays one command, acts as the bus slave, and waits for the bridge to go idle.
  task automatic run_txn(input bq_t b, input bit exp_bus, input bit do_ack, input int delay,
                         input logic [DW-1:0] rd, input bit junk, output bit to);
    int n;
    to = 0;
    foreach (b[i]) send_byte(b[i]);
    if (exp_bus) begin
      n = 0;
      while (!o_bus_req && n < 50) begin @(negedge clk); n++; end
      if (!o_bus_req) to = 1;
      else begin
        if (junk) send_byte(8'h01);
        if (do_ack) begin
          repeat (delay) @(posedge clk);
          @(posedge clk); #1;
          i_bus_ack   = 1'b1;
          i_bus_rdata = rd;
          @(posedge clk); #1;
          i_bus_ack   = 1'b0;
          i_bus_rdata = $urandom;
        end
      end
    end
    n = 0;
    while (o_busy && n < 400) begin @(negedge clk); n++; end
    if (o_busy) to = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_tx_valid, o_bus_req, o_busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: tx_valid/req/busy=%b required 000", {o_tx_valid, o_bus_req, o_busy});
    end
    checks++;
    if ({o_tx_data, o_bus_addr, o_bus_wdata, o_bus_rnw} !== '0) begin
      failures++;
      $display("FAIL reset_data: tx_data=%h addr=%h wdata=%h rnw=%b required all 0",
               o_tx_data, o_bus_addr, o_bus_wdata, o_bus_rnw);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy: got %b required 0", o_busy);
    end
  endtask

  task automatic test_read_directed();
    bq_t b, exp_tx;
    bit eb, to;
    txn_t et;
    clear_mon();
    b = '{8'h01, 8'hC0, 8'h00, 8'h00, 8'h08};
    ref_model(b, 1, 32'h0000001B, exp_tx, eb, et);
    run_txn(b, eb, 1, 3, 32'h0000001B, 0, to);
    checks++;
    if (to) begin failures++; $display("FAIL read_timeout: transaction did not complete"); end
    checks++;
    if (txn_q.size() != 1 || txn_q[0].rnw !== 1'b1 || txn_q[0].addr !== 32'hC0000008) begin
      failures++;
      $display("FAIL read_bus: reqs=%0d rnw=%b addr=%h required 1 req rnw=1 addr=c0000008",
               txn_q.size(), txn_q.size() > 0 ? txn_q[0].rnw : 1'bx, txn_q.size() > 0 ? txn_q[0].addr : 'x);
    end
    checks++;
    if (tx_q !== exp_tx) begin
      failures++;
      $display("FAIL read_tx: got %p required %p", tx_q, exp_tx);
    end
  endtask

  task automatic test_write_directed();
    bq_t b, exp_tx;
    bit eb, to;
    txn_t et;
    clear_mon();
    b = '{8'h02, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41};
    ref_model(b, 1, 32'h0, exp_tx, eb, et);
    run_txn(b, eb, 1, 2, $urandom, 0, to);
    checks++;
    if (to) begin failures++; $display("FAIL write_timeout: transaction did not complete"); end
    checks++;
    if (txn_q.size() != 1 || txn_q[0] !== {1'b0, 32'hC0000000, 32'h00000041}) begin
      failures++;
      $display("FAIL write_bus: reqs=%0d txn=%h required rnw=0 addr=c0000000 wdata=00000041",
               txn_q.size(), txn_q.size() > 0 ? txn_q[0] : 'x);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'hAA) begin
      failures++;
      $display("FAIL write_tx: got %p required AA", tx_q);
    end
  endtask

  task automatic test_bad_cmd();
    bq_t b, exp_tx;
    bit eb, to;
    txn_t et;
    logic [DW-1:0] rd;
    clear_mon();
    b = '{8'h7F};
    ref_model(b, 1, 32'h0, exp_tx, eb, et);
    run_txn(b, eb, 1, 0, 32'h0, 0, to);
    checks++;
    if (to || txn_q.size() != 0 || tx_q !== exp_tx) begin
      failures++;
      $display("FAIL bad_cmd: timeout=%0d reqs=%0d tx=%p required 0 reqs tx EE", to, txn_q.size(), tx_q);
    end
    clear_mon();
    rd = $urandom;
    b = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    ref_model(b, 1, rd, exp_tx, eb, et);
    run_txn(b, eb, 1, 1, rd, 0, to);
    checks++;
    if (to || txn_q.size() != 1 || tx_q !== exp_tx || (txn_q.size() == 1 && txn_q[0].addr !== et.addr)) begin
      failures++;
      $display("FAIL bad_cmd_recover: reqs=%0d tx=%p required addr %h tx %p", txn_q.size(), tx_q, et.addr, exp_tx);
    end
  endtask

  task automatic test_byte_timeout();
    int n;
    clear_mon();
    rdy_mode   = 1'b0;
    rdy_manual = 1'b0;
    send_byte(8'h01);
    send_byte(8'hC0);
    n = 0;
    while (!o_tx_valid && n < BTO + 20) begin @(negedge clk); n++; end
    checks++;
    if (!o_tx_valid || n < BTO - 3 || n > BTO + 3) begin
      failures++;
      $display("FAIL byte_timeout_latency: tx_valid=%b after %0d cycles required about %0d", o_tx_valid, n, BTO);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hEE) begin
        failures++;
        $display("FAIL byte_timeout_hold: cycle %0d valid=%b data=%h required 1/EE", i, o_tx_valid, o_tx_data);
      end
    end
    @(posedge clk); #1;
    rdy_manual = 1'b1;
    n = 0;
    while (o_busy && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (o_busy || tx_q.size() != 1 || tx_q[0] !== 8'hEE || run_q.size() != 0) begin
      failures++;
      $display("FAIL byte_timeout_result: busy=%b tx=%p reqs=%0d required tx EE, no req", o_busy, tx_q, run_q.size());
    end
  endtask

  task automatic test_bus_timeout();
    bq_t b, exp_tx;
    bit eb, to;
    txn_t et;
    clear_mon();
    rdy_mode   = 1'b0;
    rdy_manual = 1'b1;
    b = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    ref_model(b, 0, 32'h0, exp_tx, eb, et);
    run_txn(b, eb, 0, 0, 32'h0, 0, to);
    checks++;
    if (to || run_q.size() != 1 || (run_q.size() == 1 && run_q[0] != BSO)) begin
      failures++;
      $display("FAIL bus_timeout_req: timeout=%0d req_runs=%p required one run of %0d", to, run_q, BSO);
    end
    checks++;
    if (tx_q !== exp_tx || txn_q.size() != 0) begin
      failures++;
      $display("FAIL bus_timeout_tx: tx=%p acks=%0d required EE", tx_q, txn_q.size());
    end
  endtask

  task automatic test_random();
    bq_t b, exp_tx;
    bit eb, to, junk;
    txn_t et;
    logic [DW-1:0] rd;
    int kind;
    logic [7:0] bad;
    rdy_mode = 1'b1;
    for (int t = 0; t < 30; t++) begin
      clear_mon();
      kind = $urandom_range(0, 9);
      rd   = $urandom;
      junk = ($urandom_range(0, 3) == 0);
      b    = {};
      if (kind < 2) begin
        do bad = 8'($urandom); while (bad == 8'h01 || bad == 8'h02);
        b.push_back(bad);
      end else begin
        b.push_back(kind < 6 ? 8'h01 : 8'h02);
        for (int i = 0; i < AW / 8; i++) b.push_back(8'($urandom));
        if (kind >= 6) for (int i = 0; i < DW / 8; i++) b.push_back(8'($urandom));
      end
      ref_model(b, 1, rd, exp_tx, eb, et);
      run_txn(b, eb, 1, $urandom_range(0, 5), rd, junk, to);
      checks++;
      if (to) begin failures++; $display("FAIL rand_timeout: txn %0d did not complete", t); end
      checks++;
      if (tx_q !== exp_tx) begin
        failures++;
        $display("FAIL rand_tx: txn %0d got %p required %p", t, tx_q, exp_tx);
      end
      checks++;
      if (txn_q.size() != (eb ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_req_count: txn %0d got %0d required %0d", t, txn_q.size(), eb ? 1 : 0);
      end else if (eb) begin
        checks++;
        if (txn_q[0].rnw !== et.rnw || txn_q[0].addr !== et.addr || (!et.rnw && txn_q[0].wdata !== et.wdata)) begin
          failures++;
          $display("FAIL rand_bus: txn %0d got %h required rnw=%b addr=%h wdata=%h", t, txn_q[0], et.rnw, et.addr, et.wdata);
        end
      end
    end
    rdy_mode = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    bq_t b, exp_tx;
    bit eb, to;
    txn_t et;
    logic [DW-1:0] rd;
    int n;
    clear_mon();
    rdy_mode   = 1'b0;
    rdy_manual = 1'b1;
    rd = $urandom;
    b  = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    ref_model(b, 1, rd, exp_tx, eb, et);
    foreach (b[i]) send_byte(b[i]);
    n = 0;
    while (!o_bus_req && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    i_bus_ack   = 1'b1;
    i_bus_rdata = rd;
    @(posedge clk); #1;
    i_bus_ack   = 1'b0;
    n = 0;
    while (tx_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rdy_manual = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_q.size() != 2 || o_tx_valid !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_resp_setup: accepted=%0d valid=%b busy=%b required 2/1/1", tx_q.size(), o_tx_valid, o_busy);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({o_tx_valid, o_bus_req, o_busy, o_tx_data, o_bus_addr, o_bus_wdata, o_bus_rnw} !== '0) begin
      failures++;
      $display("FAIL mid_resp_reset_outputs: valid=%b req=%b busy=%b data=%h addr=%h wdata=%h rnw=%b required all 0",
               o_tx_valid, o_bus_req, o_busy, o_tx_data, o_bus_addr, o_bus_wdata, o_bus_rnw);
    end
    repeat (2) @(posedge clk);
    #1;
    n_rst      = 1'b1;
    rdy_manual = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (tx_q.size() != 2 || o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_resp_after_release: tx=%p valid=%b busy=%b required 2 bytes only, idle", tx_q, o_tx_valid, o_busy);
    end
    checks++;
    if (tx_q.size() == 2 && (tx_q[0] !== exp_tx[0] || tx_q[1] !== exp_tx[1])) begin
      failures++;
      $display("FAIL mid_resp_bytes: got %p required %h %h", tx_q, exp_tx[0], exp_tx[1]);
    end
  endtask

  task automatic test_stability();
    checks++;
    if (tx_unstable != 0) begin
      failures++;
      $display("FAIL tx_stability: %0d violations required 0", tx_unstable);
    end
    checks++;
    if (bus_unstable != 0) begin
      failures++;
      $display("FAIL bus_stability: %0d violations required 0", bus_unstable);
    end
  endtask

  initial begin
    n_rst       = 1'b0;
    i_rx_data   = 8'h00;
    i_rx_valid  = 1'b0;
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
    rdy_mode    = 1'b0;
    rdy_manual  = 1'b1;
    test_reset();
    test_read_directed();
    test_write_directed();
    test_bad_cmd();
    test_byte_timeout();
    rdy_manual = 1'b1;
    test_bus_timeout();
    test_random();
    test_reset_mid_resp();
    test_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
